ex_div_unit: RTL and testbench

Iterative 32-bit radix-2 divider that answers the execute stage's multi-cycle divide request. The EX-stage ALU raises a start request for DIV/DIVU and stalls the pipeline (its `ok_o` low) until this block returns ready. The block then delivers the 64-bit {remainder, quotient} pair, which is written to HI/LO.

---
 rtl/ex_div_unit.sv | 144 ++++++++++++++
 tb/tb_ex_div_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Iterative 32-bit radix-2 shift-subtract divider for DIV/DIVU; returns {remainder, quotient}.
// Latency: 32 edges from accept to ready_o (divide by zero: DONE on the accept edge itself).
// Backpressure: result is held in DONE while start_i stays high; annul_i aborts from any state.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   start_i, signed_i    request (held until ready_o) and DIV(1)/DIVU(0) select
//   annul_i              pipeline flush, returns to IDLE, wins over start_i
//   dividend_i/divisor_i rs / rt operands, sampled only on the accept edge
//   busy_o, ready_o      registered status: iterating / result valid
//   result_o             [63:32] remainder (HI), [31:0] quotient (LO)

module ex_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        annul_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  step_cnt;
    // dvd_q starts as |dividend| and shifts left each step; the freed LSBs
    // collect quotient bits, so after 32 steps it holds the whole quotient.
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic        quo_neg_q;
    logic        rem_neg_q;

    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] rem_shift;
    logic        q_bit;
    logic [31:0] rem_diff;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_final;
    logic [31:0] rem_final;

    always_comb begin
        dividend_abs = dividend_i;
        divisor_abs  = divisor_i;
        if (signed_i && dividend_i[31]) begin
            dividend_abs = ~dividend_i + 32'd1;
        end
        if (signed_i && divisor_i[31]) begin
            divisor_abs = ~divisor_i + 32'd1;
        end
    end

    // One restoring step. The compare is 33 bits wide because the shifted
    // partial remainder can exceed 32 bits. The difference only needs the low
    // 32 bits: when it is taken it is below the divisor, so bit 32 is zero.
    always_comb begin
        rem_shift = {rem_q, dvd_q[31]};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        rem_diff  = rem_shift[31:0] - dvs_q;
        rem_next  = q_bit ? rem_diff : rem_shift[31:0];
        quo_next  = {dvd_q[30:0], q_bit};
        quo_final = quo_neg_q ? (~quo_next + 32'd1) : quo_next;
        rem_final = rem_neg_q ? (~rem_next + 32'd1) : rem_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            step_cnt  <= 5'd0;
            dvd_q     <= 32'h0;
            dvs_q     <= 32'h0;
            rem_q     <= 32'h0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_o    <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= 64'h0;
        end else if (annul_i) begin
            // Flush: drop the operation but keep the last result visible.
            state    <= IDLE;
            step_cnt <= 5'd0;
            busy_o   <= 1'b0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (divisor_i == 32'h0) begin
                            // Architecturally undefined; report zero at once.
                            state    <= DONE;
                            ready_o  <= 1'b1;
                            result_o <= 64'h0;
                        end else begin
                            state     <= BUSY;
                            busy_o    <= 1'b1;
                            step_cnt  <= 5'd0;
                            dvd_q     <= dividend_abs;
                            dvs_q     <= divisor_abs;
                            rem_q     <= 32'h0;
                            quo_neg_q <= signed_i & (dividend_i[31] ^ divisor_i[31]);
                            rem_neg_q <= signed_i & dividend_i[31];
                        end
                    end
                end
                BUSY: begin
                    rem_q    <= rem_next;
                    dvd_q    <= quo_next;
                    step_cnt <= step_cnt + 5'd1;
                    if (step_cnt == 5'd31) begin
                        state    <= DONE;
                        busy_o   <= 1'b0;
                        ready_o  <= 1'b1;
                        result_o <= {rem_final, quo_final};
                    end
                end
                DONE: begin
                    // The ALU may still hold start during its stall-release
                    // cycle; only a low start ends the handshake.
                    if (!start_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    step_cnt <= 5'd0;
                    busy_o   <= 1'b0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic        annul;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_res = 64'h0;
    logic        exp_vld = 1'b0;

    ex_div_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .signed_i   (sgn),
        .annul_i    (annul),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (busy),
        .ready_o    (ready),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division in 64-bit so the signed overflow
    // case cannot trap; truncation toward zero, remainder takes dividend sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Compare process: whenever ready is up, the result must match the model;
    // ready with no outstanding request is itself an error.
    always @(negedge clk) begin
        if (!rst && ready) begin
            if (exp_vld) chk("result", result, exp_res);
            else         chk("unexpected_ready", {63'h0, ready}, 64'h0);
        end
    end

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] lit, input int hold);
        int   lat;
        logic saw_busy;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sgn      = s;
        start    = 1'b1;
        exp_res  = model(a, b, s);
        exp_vld  = 1'b1;
        chk({name, "_model"}, exp_res, lit);
        lat      = 0;
        saw_busy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Operands after acceptance must be ignored.
                dividend = ~a;
                divisor  = b ^ 32'h5;
                sgn      = ~s;
            end
            if (busy) saw_busy = 1'b1;
        end while (!ready && lat < 100);
        // Edges seen including the accept edge: 33 for a real divide
        // (32 after accept), 1 for divide by zero.
        chk({name, "_latency"}, 64'(lat), (b == 32'h0) ? 64'd1 : 64'd33);
        chk({name, "_busy_seen"}, {63'h0, saw_busy}, {63'h0, (b != 32'h0)});
        repeat (hold) begin
            @(negedge clk);
            chk({name, "_hold_ready"}, {62'h0, busy, ready}, 64'd1);
        end
        start = 1'b0;
        @(negedge clk);
        chk({name, "_release"}, {62'h0, busy, ready}, 64'd0);
        exp_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        sgn      = 1'b0;
        annul    = 1'b0;
        dividend = 32'h0;
        divisor  = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, ready, result}, 66'h0);
        rst = 1'b0;

        do_div("u100_7",   32'd100,       32'd7,         1'b0, {32'd2, 32'd14}, 0);
        do_div("s_m7_2",   32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        do_div("s_7_m2",   32'd7,         32'hFFFFFFFE,  1'b1, {32'h00000001, 32'hFFFFFFFD}, 5);
        do_div("s_ovf",    32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h0, 32'h80000000}, 0);
        do_div("u_ovfops", 32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000, 32'h0}, 0);
        do_div("u_big",    32'hFFFFFFFF,  32'h00000010,  1'b0, {32'h0000000F, 32'h0FFFFFFF}, 0);
        do_div("s_big",    32'hFFFFFFFF,  32'h00000010,  1'b1, {32'hFFFFFFFF, 32'h0}, 0);
        do_div("u_div0",   32'd1234,      32'd0,         1'b0, 64'h0, 2);
        do_div("s_div0",   32'd1234,      32'd0,         1'b1, 64'h0, 0);

        // Annul at step 10 of 55/5: back to IDLE, no ready afterwards.
        @(negedge clk);
        dividend = 32'd55;
        divisor  = 32'd5;
        sgn      = 1'b0;
        start    = 1'b1;
        repeat (10) @(negedge clk);
        chk("annul_busy_before", {63'h0, busy}, 64'd1);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_idle", {62'h0, busy, ready}, 64'd0);
        repeat (40) @(negedge clk);
        chk("annul_no_ready", {62'h0, busy, ready}, 64'd0);
        do_div("u55_5", 32'd55, 32'd5, 1'b0, {32'd0, 32'd11}, 0);

        // annul together with start in IDLE: request is not taken.
        @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        annul    = 1'b1;
        @(negedge clk);
        chk("annul_start_idle", {62'h0, busy, ready}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        chk("annul_start_idle2", {62'h0, busy, ready}, 64'd0);

        // Asynchronous reset mid-BUSY: outputs clear before the next edge.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", {63'h0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst", {busy, ready, result}, 66'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_no_ready", {busy, ready, result}, 66'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
